// File: rtl/ex_mem_pkg.sv
// Shared pipeline definitions: field widths and control-bit positions
// used by the EX/MEM register and its neighbours.
package ex_mem_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int WB_W   = 2;
  localparam int MEM_W  = 2;

  // Control-bit positions inside the WB [1:0] and MEM [2:3] bundles
  localparam int MEMTOREG = 0;
  localparam int REGWRITE = 1;
  localparam int MEMREAD  = 2;
  localparam int MEMWRITE = 3;

endpackage

// File: rtl/ex_mem_pipe_reg.sv
// Width-N D register with asynchronous active-high clear; one per pipeline field.
module pipe_reg #(
  parameter int N = 1
) (
  input  logic         clock,
  input  logic         clear,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Capture d on every rising edge; clear overrides immediately
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= {N{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: every execute-stage result and downstream control
// bundle is held for exactly one cycle; reset turns the slot into a bubble.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_REG_W  = REG_W,
  parameter int P_WB_W   = WB_W,
  parameter int P_MEM_W  = MEM_W
) (
  input  logic                                 clock,
  input  logic                                 startin,
  input  logic [P_DATA_W-1:0]                  pc_beq_input,
  input  logic [P_DATA_W-1:0]                  alu_result_input,
  input  logic [P_DATA_W-1:0]                  read_data_2_input,
  input  logic [P_REG_W-1:0]                   write_register_input,
  input  logic                                 alu_zero_input,
  input  logic [P_WB_W-1:0]                    WB_input,
  input  logic [MEMREAD:MEMREAD+P_MEM_W-1]     MEM_input,
  output logic [P_DATA_W-1:0]                  pc_beq_output,
  output logic [P_DATA_W-1:0]                  alu_result_output,
  output logic [P_DATA_W-1:0]                  read_data_2_output,
  output logic [P_REG_W-1:0]                   write_register_output,
  output logic                                 alu_zero_output,
  output logic [P_WB_W-1:0]                    WB_output,
  output logic [MEMREAD:MEMREAD+P_MEM_W-1]     MEM_output
);

  pipe_reg #(.N(P_DATA_W)) u_pc_beq (
    .clock(clock), .clear(startin), .d(pc_beq_input), .q(pc_beq_output)
  );

  pipe_reg #(.N(P_DATA_W)) u_alu_result (
    .clock(clock), .clear(startin), .d(alu_result_input), .q(alu_result_output)
  );

  pipe_reg #(.N(P_DATA_W)) u_read_data_2 (
    .clock(clock), .clear(startin), .d(read_data_2_input), .q(read_data_2_output)
  );

  pipe_reg #(.N(P_REG_W)) u_write_register (
    .clock(clock), .clear(startin), .d(write_register_input), .q(write_register_output)
  );

  pipe_reg #(.N(1)) u_alu_zero (
    .clock(clock), .clear(startin), .d(alu_zero_input), .q(alu_zero_output)
  );

  pipe_reg #(.N(P_WB_W)) u_wb (
    .clock(clock), .clear(startin), .d(WB_input), .q(WB_output)
  );

  // MEM keeps its [2:3] numbering: MemRead lands on d[1], MemWrite on d[0]
  pipe_reg #(.N(P_MEM_W)) u_mem (
    .clock(clock), .clear(startin), .d(MEM_input), .q(MEM_output)
  );

endmodule

// File: tb/tb_ex_mem.sv
// Randomised self-checking bench for ex_mem against a one-cycle-delay reference model.
module tb_ex_mem;

  localparam int VW = 106;

  logic          clock;
  logic          startin;
  logic [VW-1:0] in_vec;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] out_vec;

  logic [31:0] pc_beq_input, alu_result_input, read_data_2_input;
  logic [4:0]  write_register_input;
  logic        alu_zero_input;
  logic [1:0]  WB_input;
  logic [2:3]  MEM_input;
  logic [31:0] pc_beq_output, alu_result_output, read_data_2_output;
  logic [4:0]  write_register_output;
  logic        alu_zero_output;
  logic [1:0]  WB_output;
  logic [2:3]  MEM_output;

  int checks;
  int failures;

  assign {pc_beq_input, alu_result_input, read_data_2_input, write_register_input,
          alu_zero_input, WB_input, MEM_input} = in_vec;
  assign out_vec = {pc_beq_output, alu_result_output, read_data_2_output,
                    write_register_output, alu_zero_output, WB_output, MEM_output};

  ex_mem dut (
    .clock                 (clock),
    .startin               (startin),
    .pc_beq_input          (pc_beq_input),
    .alu_result_input      (alu_result_input),
    .read_data_2_input     (read_data_2_input),
    .write_register_input  (write_register_input),
    .alu_zero_input        (alu_zero_input),
    .WB_input              (WB_input),
    .MEM_input             (MEM_input),
    .pc_beq_output         (pc_beq_output),
    .alu_result_output     (alu_result_output),
    .read_data_2_output    (read_data_2_output),
    .write_register_output (write_register_output),
    .alu_zero_output       (alu_zero_output),
    .WB_output             (WB_output),
    .MEM_output            (MEM_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
    end
  endtask

  // Model: what the register should show after this edge is whatever
  // the inputs were at the edge, or nothing at all if reset is held.
  task automatic tick(input string tag);
    @(posedge clock);
    exp_vec = startin ? {VW{1'b0}} : in_vec;
    #1;
    check_val(tag, out_vec, exp_vec);
  endtask

  task automatic assert_reset(input string tag);
    startin = 1'b1;
    exp_vec = {VW{1'b0}};
    #1;
    check_val(tag, out_vec, exp_vec);
  endtask

  logic [VW-1:0] set1, set2, set3;
  logic [127:0]  rnd;

  initial begin
    checks   = 0;
    failures = 0;
    set1 = {32'h0000_0004, 32'hA5A5_A5A5, 32'h1234_5678, 5'h1F, 1'b0, 2'b10, 2'b01};
    set2 = {32'h0000_0008, 32'h5A5A_5A5A, 32'h8765_4321, 5'h0F, 1'b1, 2'b01, 2'b11};
    set3 = {32'h0000_000C, 32'hFFFF_FFFF, 32'h1111_1111, 5'h0A, 1'b0, 2'b11, 2'b10};

    startin = 1'b0;
    in_vec  = set1;
    tick("capture");

    @(negedge clock);
    assert_reset("async_reset");
    tick("reset_edge");
    @(negedge clock);
    startin = 1'b0;
    tick("release");
    check_val("release_set1", out_vec, set1);

    @(negedge clock);
    in_vec = set2;
    tick("stream_2");
    @(negedge clock);
    in_vec = set3;
    tick("stream_3");

    @(negedge clock);
    assert_reset("mid_reset");
    tick("mid_reset_edge");
    @(negedge clock);
    startin = 1'b0;
    tick("after_mid_reset");
    check_val("after_mid_set3", out_vec, set3);

    // Walking one: outputs must hold until the edge, then mirror exactly that bit
    for (int b = 0; b < VW; b++) begin
      @(negedge clock);
      in_vec = {VW{1'b0}};
      in_vec[b] = 1'b1;
      #1;
      check_val("walk_hold", out_vec, exp_vec);
      tick("walk_one");
    end

    // Random stream with sporadic mid-cycle resets
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      in_vec = rnd[VW-1:0];
      if (startin) begin
        startin = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        assert_reset("rand_reset");
      end
      #1;
      check_val("rand_hold", out_vec, exp_vec);
      tick("rand_edge");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
